rsp_coef_ahb_slv: RTL and testbench
===================================

// Module: rsp_coef_ahb_slv
// PURPOSE
// - AHB-Lite slave behind the rsp_s1_prep cfg port (hclk domain). Captures host coefficient writes.
// - Twiddle window: packs pairs of 32-bit writes into 64-bit entries and writes them to the twiddle RAM.
// - ET window: writes 32-bit entries straight to the ET RAM.
// - Both RAM pointers auto-increment. Status/control registers let firmware poll fill level and rewind.
// PARAMETERS
// TW_DEPTH    136     twiddle RAM entries (64b each)
// ET_DEPTH    32      ET RAM entries (32b each)
// TW_WIN_OFS  'h1400  twiddle write window (haddr[15:0])
// ET_WIN_OFS  'h1800  ET write window
// STAT_OFS    'h1C00  status register, read-only
// CTRL_OFS    'h1C04  control register, write-only
// PORTS
// hclk          in   1    clock
// hreset        in   1    reset, asynchronous, active-high
// hsel          in   1    slave select
// hreadyin      in   1    bus ready (previous transfer done)
// htrans        in   2    IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
// hwrite        in   1    1=write
// haddr         in   32   byte address; only [15:0] decoded
// hsize         in   3    only 3'd2 (word) legal
// hburst        in   3    ignored (each beat decoded independently)
// hwdata        in   32   write data, data phase
// hrdata        out  32   read data, data phase
// hready        out  1    transfer-done
// hresp         out  1    0=OKAY 1=ERROR
// o_tw_wr_en    out  1    twiddle RAM write strobe
// o_tw_wr_addr  out  $clog2(TW_DEPTH)  twiddle entry index
// o_tw_wr_data  out  64   {first word, second word}
// o_et_wr_en    out  1    ET RAM write strobe
// o_et_wr_addr  out  $clog2(ET_DEPTH)  ET entry index
// o_et_wr_data  out  32   ET entry
// o_tw_done     out  1    level: twiddle count == TW_DEPTH
// o_et_done     out  1    level: ET count == ET_DEPTH
// BEHAVIOUR
// - Reset: all outputs 0 except hready=1. Counts, half flag and done flags cleared; a held first word is discarded.
// - Reset is honoured mid-transfer with no RAM write issued.
// - Address phase accepted when hsel & hreadyin & htrans[1]. Register addr/write/size for the data phase.
// - IDLE and BUSY transfers: OKAY, zero wait, no effect.
// - Error conditions (no side effects, counts unchanged):
//   - hsize != 2;
//   - unmapped offset;
//   - read of a window or CTRL;
//   - write to STAT;
//   - TW window write while o_tw_done;
//   - ET window write while o_et_done.
// - Response FSM:
//   - OKAY: hready=1, hresp=0, zero wait state.
//   - ERR1: hready=0, hresp=1, entered on an error data phase.
//   - ERR2: hready=1, hresp=1, then back to OKAY.
//   - Address phase presented during ERR2 is accepted normally.
// - TW window, half=0: store hwdata as hi word; half<=1; no RAM write.
// - TW window, half=1:
//   - next cycle o_tw_wr_en=1 for exactly 1 cycle;
//   - data={hi,hwdata}, addr=tw_cnt;
//   - tw_cnt++, half<=0.
// - ET window: next cycle o_et_wr_en=1 for 1 cycle; data=hwdata, addr=et_cnt; et_cnt++.
// - Write latency: strobe asserted in the cycle after the data phase (registered). Strobe data/addr hold until the next strobe.
// - Counts saturate at DEPTH and never wrap. o_*_done asserts in the same cycle as the final strobe.
// - STAT read data (data phase, 0 when not a STAT read):
//   - [31]=half, [30]=tw_done, [29]=et_done;
//   - [23:16]=et_cnt, [15:0]=tw_cnt (zero-extended).
// - CTRL write:
//   - bit0: tw_cnt, half, tw_done <= 0;
//   - bit1: et_cnt, et_done <= 0;
//   - both bits allowed together; other bits ignored.
// - CTRL is effective the cycle after its data phase. A TW/ET write in that data phase uses the pre-clear pointer.
// - Back-to-back NONSEQ writes every cycle are sustained: one beat per cycle, no stall.
// TESTING
// - 272 word writes to 'h1400, values w0..w271:
//   - 136 strobes; entry k = {w(2k), w(2k+1)} at addr k;
//   - o_tw_done rises with strobe 135; STAT[15:0]=136.
// - 273rd write to 'h1400: ERROR, 2 cycles (hready 0 then 1, hresp=1); no strobe; STAT unchanged.
// - 32 writes to 'h1800 then 1 more:
//   - addr 0..31; o_et_done=1;
//   - 33rd write: ERROR; STAT[23:16]=32.
// - One write to 'h1400 (half=1), then CTRL write 1: STAT reads 0; next pair lands at addr 0.
// - Error cases: hsize=1 write to 'h1800; read of 'h1400; write to 'h1C00 -> each gives ERROR, no side effects.
// - Reset between the two halves of a pair: no strobe issued; after release STAT=0; new pair writes addr 0.

Source files
------------

// File: rtl/rsp_coef_ahb_slv.sv
// rsp_coef_ahb_slv: AHB-Lite cfg slave capturing twiddle/ET coefficient writes into RAM strobes
module rsp_coef_ahb_slv #(
   parameter int          TW_DEPTH   = 136,
   parameter int          ET_DEPTH   = 32,
   parameter logic [15:0] TW_WIN_OFS = 16'h1400,
   parameter logic [15:0] ET_WIN_OFS = 16'h1800,
   parameter logic [15:0] STAT_OFS   = 16'h1C00,
   parameter logic [15:0] CTRL_OFS   = 16'h1C04,
   localparam int         TW_AW      = $clog2(TW_DEPTH),
   localparam int         ET_AW      = $clog2(ET_DEPTH)
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic             hsel,
   input  logic             hreadyin,
   input  logic [1:0]       htrans,
   input  logic             hwrite,
   input  logic [31:0]      haddr,
   input  logic [2:0]       hsize,
   input  logic [2:0]       hburst,
   input  logic [31:0]      hwdata,
   output logic [31:0]      hrdata,
   output logic             hready,
   output logic             hresp,
   output logic             o_tw_wr_en,
   output logic [TW_AW-1:0] o_tw_wr_addr,
   output logic [63:0]      o_tw_wr_data,
   output logic             o_et_wr_en,
   output logic [ET_AW-1:0] o_et_wr_addr,
   output logic [31:0]      o_et_wr_data,
   output logic             o_tw_done,
   output logic             o_et_done
);
   localparam int TW_CW = $clog2(TW_DEPTH + 1);
   localparam int ET_CW = $clog2(ET_DEPTH + 1);
   localparam logic [TW_CW-1:0] TW_FULL = TW_CW'(TW_DEPTH);
   localparam logic [ET_CW-1:0] ET_FULL = ET_CW'(ET_DEPTH);
   typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;
   state_t           state_q, state_d;
   logic [TW_CW-1:0] tw_cnt, tw_cnt_nxt;
   logic [ET_CW-1:0] et_cnt, et_cnt_nxt;
   logic             half, half_nxt;
   logic [31:0]      hi_word;
   logic             dp_tw, dp_et, dp_ctrl, dp_stat;
   logic             acc, a_tw, a_et, a_stat, a_ctrl, a_err;
   logic             clr_tw, clr_et;
   logic [15:0]      ofs;
   logic             unused;
   assign unused = ^{hburst, haddr[31:16]};
   assign ofs    = haddr[15:0];
   assign acc    = hsel & hreadyin & htrans[1] & hready;
   assign a_tw   = ofs[15:10] == TW_WIN_OFS[15:10];
   assign a_et   = ofs[15:10] == ET_WIN_OFS[15:10];
   assign a_stat = ofs == STAT_OFS;
   assign a_ctrl = ofs == CTRL_OFS;
   // full checks look at next-cycle counts so a write pipelined behind the final entry is refused
   assign a_err  = (hsize != 3'd2) | ~(a_tw | a_et | a_stat | a_ctrl) | (a_stat ? hwrite : ~hwrite) |
                   (a_tw & (tw_cnt_nxt == TW_FULL)) | (a_et & (et_cnt_nxt == ET_FULL));
   assign clr_tw = dp_ctrl & hwdata[0];
   assign clr_et = dp_ctrl & hwdata[1];
   assign o_tw_done = tw_cnt == TW_FULL;
   assign o_et_done = et_cnt == ET_FULL;
   assign hrdata = dp_stat ? {half, o_tw_done, o_et_done, 5'd0, 8'(et_cnt), 16'(tw_cnt)} : 32'd0;
   // next pointer/half values, shared by the register update and the address-phase full check
   always_comb begin
      tw_cnt_nxt = clr_tw ? '0 : (dp_tw & half) ? tw_cnt + 1'b1 : tw_cnt;
      half_nxt   = clr_tw ? 1'b0 : dp_tw ? ~half : half;
      et_cnt_nxt = clr_et ? '0 : dp_et ? et_cnt + 1'b1 : et_cnt;
   end
   // response FSM next state and bus handshake outputs
   always_comb begin
      state_d = state_q;
      hready  = 1'b1;
      hresp   = 1'b0;
      case (state_q)
         S_ERR1: begin
            hready  = 1'b0;
            hresp   = 1'b1;
            state_d = S_ERR2;
         end
         S_ERR2: begin
            hresp   = 1'b1;
            state_d = (acc & a_err) ? S_ERR1 : S_OKAY;
         end
         default: state_d = (acc & a_err) ? S_ERR1 : S_OKAY;
      endcase
   end
   // response state register
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) state_q <= S_OKAY;
      else state_q <= state_d;
   end
   // data-phase decode, only legal accepted transfers leave a flag set
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dp_tw   <= 1'b0;
         dp_et   <= 1'b0;
         dp_ctrl <= 1'b0;
         dp_stat <= 1'b0;
      end else begin
         dp_tw   <= acc & ~a_err & a_tw;
         dp_et   <= acc & ~a_err & a_et;
         dp_ctrl <= acc & ~a_err & a_ctrl;
         dp_stat <= acc & ~a_err & a_stat;
      end
   end
   // fill pointers, pair half flag and held first word
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         tw_cnt  <= '0;
         et_cnt  <= '0;
         half    <= 1'b0;
         hi_word <= 32'd0;
      end else begin
         tw_cnt <= tw_cnt_nxt;
         et_cnt <= et_cnt_nxt;
         half   <= half_nxt;
         if (dp_tw & ~half) hi_word <= hwdata;
      end
   end
   // registered RAM strobes; address/data hold until the next strobe
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         o_tw_wr_en   <= 1'b0;
         o_tw_wr_addr <= '0;
         o_tw_wr_data <= 64'd0;
         o_et_wr_en   <= 1'b0;
         o_et_wr_addr <= '0;
         o_et_wr_data <= 32'd0;
      end else begin
         o_tw_wr_en <= dp_tw & half;
         o_et_wr_en <= dp_et;
         if (dp_tw & half) begin
            o_tw_wr_addr <= TW_AW'(tw_cnt);
            o_tw_wr_data <= {hi_word, hwdata};
         end
         if (dp_et) begin
            o_et_wr_addr <= ET_AW'(et_cnt);
            o_et_wr_data <= hwdata;
         end
      end
   end
endmodule

// File: tb/tb_rsp_coef_ahb_slv.sv
// tb_rsp_coef_ahb_slv: scoreboard bench for the coefficient AHB slave
module tb_rsp_coef_ahb_slv;
   logic        hclk, hreset, hsel, hreadyin, hwrite, hready, hresp;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata, hrdata;
   logic [2:0]  hsize, hburst;
   logic        o_tw_wr_en, o_et_wr_en, o_tw_done, o_et_done;
   logic [7:0]  o_tw_wr_addr;
   logic [63:0] o_tw_wr_data;
   logic [4:0]  o_et_wr_addr;
   logic [31:0] o_et_wr_data;
   typedef struct packed {logic [7:0] a; logic [63:0] d; logic done;} tw_e_t;
   typedef struct packed {logic [4:0] a; logic [31:0] d; logic done;} et_e_t;
   typedef struct packed {logic err; logic rd; logic [31:0] d;} rsp_e_t;
   tw_e_t  tw_q[$];
   et_e_t  et_q[$];
   rsp_e_t rsp_q[$];
   int     n_chk = 0, n_fail = 0;
   logic   in_dp = 1'b0, saw_wait = 1'b0;
   assign hreadyin = hready;
   rsp_coef_ahb_slv dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .hreadyin(hreadyin), .htrans(htrans),
      .hwrite(hwrite), .haddr(haddr), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .o_tw_wr_en(o_tw_wr_en), .o_tw_wr_addr(o_tw_wr_addr), .o_tw_wr_data(o_tw_wr_data),
      .o_et_wr_en(o_et_wr_en), .o_et_wr_addr(o_et_wr_addr), .o_et_wr_data(o_et_wr_data),
      .o_tw_done(o_tw_done), .o_et_done(o_et_done)
   );
   initial hclk = 1'b0;
   always #5 hclk = ~hclk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] tw_w(input int i);
      return 32'h7100_0000 + 32'(i * 3);
   endfunction
   function automatic logic [31:0] et_w(input int i);
      return 32'hE500_0000 + 32'(i * 5);
   endfunction
   // one pipelined beat: address now, data driven after the accepting edge
   task automatic beat(input logic wr, input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d,
                       input logic err, input logic [31:0] rd, input logic push = 1'b1);
      rsp_e_t e;
      hsel = 1'b1; htrans = 2'd2; hwrite = wr; haddr = {16'h0, a}; hsize = sz;
      if (push) begin
         e.err = err; e.rd = ~wr & ~err; e.d = rd;
         rsp_q.push_back(e);
      end
      for (int n = 0; n < 16 && !hready; n++) begin
         @(posedge hclk); #1;
      end
      if (!hready) begin
         n_fail++;
         $display("FAIL bus_timeout: hready stuck at 0 for addr %0h", a);
      end
      @(posedge hclk); #1;
      hwdata = d;
      hsel = 1'b0; htrans = 2'd0;
   endtask
   task automatic idle(input int n);
      hsel = 1'b0; htrans = 2'd0;
      repeat (n) begin
         @(posedge hclk); #1;
      end
   endtask
   // monitor: RAM strobes and bus responses against the expected queues
   always @(negedge hclk) begin
      if (hreset) begin
         in_dp    <= 1'b0;
         saw_wait <= 1'b0;
      end else begin
         if (o_tw_wr_en) begin
            if (tw_q.size() == 0) begin
               n_fail++;
               $display("FAIL tw_unexpected: strobe addr %0h data %0h with none required", o_tw_wr_addr, o_tw_wr_data);
            end else begin
               tw_e_t t;
               t = tw_q.pop_front();
               chk("tw_addr", 64'(o_tw_wr_addr), 64'(t.a));
               chk("tw_data", o_tw_wr_data, t.d);
               chk("tw_done", 64'(o_tw_done), 64'(t.done));
            end
         end
         if (o_et_wr_en) begin
            if (et_q.size() == 0) begin
               n_fail++;
               $display("FAIL et_unexpected: strobe addr %0h data %0h with none required", o_et_wr_addr, o_et_wr_data);
            end else begin
               et_e_t t;
               t = et_q.pop_front();
               chk("et_addr", 64'(o_et_wr_addr), 64'(t.a));
               chk("et_data", 64'(o_et_wr_data), 64'(t.d));
               chk("et_done", 64'(o_et_done), 64'(t.done));
            end
         end
         if (in_dp && !hready) begin
            chk("err1_hresp", 64'(hresp), 64'd1);
            saw_wait <= 1'b1;
         end else if (in_dp) begin
            if (rsp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: data phase with no transfer issued");
            end else begin
               rsp_e_t r;
               r = rsp_q.pop_front();
               chk("hresp", 64'(hresp), 64'(r.err));
               chk("wait_state", 64'(saw_wait), 64'(r.err));
               if (r.rd) chk("hrdata", 64'(hrdata), 64'(r.d));
            end
            saw_wait <= 1'b0;
         end else chk("idle_resp", 64'({hready, hresp}), 64'd2);
         if (hready) in_dp <= hsel & hreadyin & htrans[1];
      end
   end
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      hreset = 1'b1; hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 32'd0;
      hsize = 3'd2; hburst = 3'd0; hwdata = 32'd0;
      repeat (3) @(posedge hclk);
      #1 hreset = 1'b0;
      chk("rst_hready", 64'(hready), 64'd1);
      chk("rst_hresp", 64'(hresp), 64'd0);
      chk("rst_strobes", 64'({o_tw_wr_en, o_et_wr_en, o_tw_done, o_et_done}), 64'd0);
      chk("rst_hrdata", 64'(hrdata), 64'd0);
      chk("rst_tw_data", o_tw_wr_data, 64'd0);
      // fill the twiddle RAM with back-to-back beats
      for (int i = 0; i < 272; i++) begin
         if (i % 2 == 1) tw_q.push_back('{a: 8'(i / 2), d: {tw_w(i - 1), tw_w(i)}, done: (i == 271)});
         beat(1'b1, 16'h1400, 3'd2, tw_w(i), 1'b0, 32'd0);
      end
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h4000_0088);
      beat(1'b1, 16'h1400, 3'd2, 32'hDEAD_BEEF, 1'b1, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h4000_0088);
      idle(2);
      // fill the ET RAM, then one too many
      for (int i = 0; i < 32; i++) begin
         et_q.push_back('{a: 5'(i), d: et_w(i), done: (i == 31)});
         beat(1'b1, 16'h1800, 3'd2, et_w(i), 1'b0, 32'd0);
      end
      beat(1'b1, 16'h1800, 3'd2, 32'h1234_5678, 1'b1, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h6020_0088);
      idle(2);
      // rewind both, half-fill, rewind twiddle, fresh pair at 0
      beat(1'b1, 16'h1C04, 3'd2, 32'h0000_0003, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0000_0000);
      beat(1'b1, 16'h1400, 3'd2, 32'hAAAA_0001, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h8000_0000);
      beat(1'b1, 16'h1C04, 3'd2, 32'hFFFF_FFF1, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0000_0000);
      tw_q.push_back('{a: 8'd0, d: 64'hB0B0_0000_B1B1_0001, done: 1'b0});
      beat(1'b1, 16'h1400, 3'd2, 32'hB0B0_0000, 1'b0, 32'd0);
      beat(1'b1, 16'h1400, 3'd2, 32'hB1B1_0001, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0000_0001);
      et_q.push_back('{a: 5'd0, d: 32'hCAFE_F00D, done: 1'b0});
      beat(1'b1, 16'h1800, 3'd2, 32'hCAFE_F00D, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0001_0001);
      idle(1);
      // illegal accesses leave no trace
      beat(1'b1, 16'h1800, 3'd1, 32'h0BAD_0001, 1'b1, 32'd0);
      beat(1'b0, 16'h1400, 3'd2, 32'd0, 1'b1, 32'd0);
      beat(1'b1, 16'h1C00, 3'd2, 32'h0000_0003, 1'b1, 32'd0);
      beat(1'b0, 16'h1C04, 3'd2, 32'd0, 1'b1, 32'd0);
      beat(1'b1, 16'h0040, 3'd2, 32'h0BAD_0002, 1'b1, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0001_0001);
      // BUSY beats are ignored
      hsel = 1'b1; htrans = 2'd1; hwrite = 1'b1; haddr = 32'h1800; hsize = 3'd2; hwdata = 32'h0BAD_0003;
      repeat (2) begin
         @(posedge hclk); #1;
      end
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0001_0001);
      // reset between the two halves of a pair
      beat(1'b1, 16'h1400, 3'd2, 32'hC0C0_0000, 1'b0, 32'd0);
      beat(1'b1, 16'h1400, 3'd2, 32'hC1C1_0001, 1'b0, 32'd0, 1'b0);
      hreset = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b0;
      chk("mid_rst_strobe", 64'({o_tw_wr_en, o_et_wr_en, o_tw_done}), 64'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0000_0000);
      tw_q.push_back('{a: 8'd0, d: 64'hD0D0_0000_D1D1_0001, done: 1'b0});
      beat(1'b1, 16'h1400, 3'd2, 32'hD0D0_0000, 1'b0, 32'd0);
      beat(1'b1, 16'h1400, 3'd2, 32'hD1D1_0001, 1'b0, 32'd0);
      beat(1'b0, 16'h1C00, 3'd2, 32'd0, 1'b0, 32'h0000_0001);
      idle(4);
      chk("tw_q_drained", 64'(tw_q.size()), 64'd0);
      chk("et_q_drained", 64'(et_q.size()), 64'd0);
      chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
